// File: rtl/fpnew_i2fcast_pipe.sv
// ---------------------------------------------------------------------------
// fpnew_i2fcast_pipe
//
// Two-stage pipelined integer-to-floating-point converter with a
// valid/ready handshake.
//   Stage A: takes the sign and magnitude of the integer operand.
//   Stage B: normalises, rounds and packs the result. Its register drives
//            the outputs directly.
// A sideband tag travels with each operation.
//
// Destination format encoding (DstFpFormat):
//   0 = FP32 (8/23)
//   1 = FP64 (11/52)
//   2 = FP16 (5/10)
//   3 = FP8  (5/2)
//   4 = FP16ALT (8/7)
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous, active-high reset
//   operand_i       integer operand (IntWidth bits)
//   is_signed_i     1: operand is two's complement, 0: unsigned
//   rnd_mode_i      RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4
//   tag_i / tag_o   sideband carried through the pipe
//   in_valid_i / in_ready_o     input handshake
//   flush_i         drop all in-flight operations
//   result_o        packed FP result (DST_WIDTH bits)
//   status_o        {NV, DZ, OF, UF, NX}
//   extension_bit_o constant 1 (result is NaN-boxed)
//   out_valid_o / out_ready_i   output handshake
//   busy_o          some stage holds a valid operation
// ---------------------------------------------------------------------------
module fpnew_i2fcast_pipe #(
    parameter int unsigned IntWidth    = 32,
    parameter int unsigned DstFpFormat = 0,
    parameter type         TagType     = logic,
    localparam int unsigned DST_EXP_BITS =
        (DstFpFormat == 1) ? 11 : (DstFpFormat == 2) ? 5 :
        (DstFpFormat == 3) ? 5  : 8,
    localparam int unsigned DST_MAN_BITS =
        (DstFpFormat == 1) ? 52 : (DstFpFormat == 2) ? 10 :
        (DstFpFormat == 3) ? 2  : (DstFpFormat == 4) ? 7 : 23,
    localparam int unsigned DST_WIDTH = 1 + DST_EXP_BITS + DST_MAN_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IntWidth-1:0]  operand_i,
    input  logic                 is_signed_i,
    input  logic [2:0]           rnd_mode_i,
    input  TagType               tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [DST_WIDTH-1:0] result_o,
    output logic [4:0]           status_o,
    output logic                 extension_bit_o,
    output TagType               tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    localparam int unsigned DST_BIAS = (1 << (DST_EXP_BITS - 1)) - 1;
    localparam int unsigned LZW      = $clog2(IntWidth + 1);
    // Fraction below the hidden bit, padded so that the mantissa, round
    // and sticky slices always exist even when IntWidth-1 < DST_MAN_BITS.
    localparam int unsigned FRAC_W   = IntWidth - 1 + DST_MAN_BITS + 2;
    // The exponent is held at 32 bits so that a rounding carry past the
    // largest exponent is never lost.
    localparam int unsigned EXPW     = 32;
    localparam int unsigned RW       = EXPW + DST_MAN_BITS;
    localparam logic [EXPW-1:0] MAX_EXP = EXPW'((1 << DST_EXP_BITS) - 1);

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    // Returns the number of leading zeros. An all-zero input returns IntWidth.
    function automatic logic [LZW-1:0] count_lz(input logic [IntWidth-1:0] v);
        count_lz = LZW'(IntWidth);
        for (int i = 0; i < IntWidth; i++) begin
            if (v[i]) count_lz = LZW'(IntWidth - 1 - i);
        end
    endfunction

    // ---------------- pipeline registers ----------------
    logic                 a_valid;
    logic                 a_sign;
    logic [IntWidth-1:0]  a_mag;
    logic                 a_zero;
    logic [2:0]           a_rnd;
    TagType               a_tag;

    logic                 b_valid;
    logic [DST_WIDTH-1:0] b_result;
    logic [4:0]           b_status;
    TagType               b_tag;

    // ---------------- handshake ----------------
    logic b_adv;
    logic a_adv;

    assign b_adv      = ~b_valid | out_ready_i;
    assign a_adv      = ~a_valid | b_adv;
    assign in_ready_o = a_adv & ~flush_i & ~rst_i;

    // ---------------- stage A combinational ----------------
    logic                in_sign;
    logic [IntWidth-1:0] in_mag;

    assign in_sign = is_signed_i & operand_i[IntWidth-1];
    // The signed minimum negates onto itself, which is exactly 2^(IntWidth-1)
    // when the value is read as unsigned.
    assign in_mag  = in_sign ? (~operand_i + IntWidth'(1)) : operand_i;

    // ---------------- stage B combinational ----------------
    logic [LZW-1:0]          lzc;
    logic [IntWidth-1:0]     norm;
    logic [FRAC_W-1:0]       frac_ext;
    logic [DST_MAN_BITS-1:0] mant;
    logic                    round_bit;
    logic                    sticky;
    logic [EXPW-1:0]         exp_pre;
    logic                    inc;
    logic [RW-1:0]           rounded;
    logic [EXPW-1:0]         exp_rnd;
    logic                    overflow;
    logic                    inexact;
    logic                    use_inf;
    logic [DST_WIDTH-1:0]    res_next;
    logic [4:0]              status_next;
    logic                    unused_bits;

    assign lzc      = count_lz(a_mag);
    assign norm     = a_mag << lzc;
    assign frac_ext = {norm[IntWidth-2:0], {(DST_MAN_BITS + 2){1'b0}}};
    assign mant     = frac_ext[FRAC_W-1 -: DST_MAN_BITS];
    assign round_bit = frac_ext[FRAC_W-1-DST_MAN_BITS];
    assign sticky   = |frac_ext[FRAC_W-2-DST_MAN_BITS:0];
    assign exp_pre  = EXPW'(IntWidth - 1) - EXPW'(lzc) + EXPW'(DST_BIAS);
    // The hidden bit is implied by the exponent and never stored.
    assign unused_bits = norm[IntWidth-1];

    always_comb begin
        inc = 1'b0;
        case (a_rnd)
            RNE:     inc = round_bit & (sticky | mant[0]);
            RTZ:     inc = 1'b0;
            RDN:     inc = (round_bit | sticky) & a_sign;
            RUP:     inc = (round_bit | sticky) & ~a_sign;
            RMM:     inc = round_bit;
            default: inc = round_bit & (sticky | mant[0]);
        endcase
    end

    // A mantissa carry ripples straight into the exponent field.
    assign rounded  = {exp_pre, mant} + RW'(inc);
    assign exp_rnd  = rounded[RW-1 -: EXPW];
    assign overflow = (exp_rnd >= MAX_EXP);
    assign inexact  = round_bit | sticky | overflow;

    // On overflow, pick infinity or the largest finite value. The choice
    // depends on whether the rounding direction points away from zero.
    always_comb begin
        use_inf = 1'b1;
        case (a_rnd)
            RTZ:     use_inf = 1'b0;
            RDN:     use_inf = a_sign;
            RUP:     use_inf = ~a_sign;
            default: use_inf = 1'b1;
        endcase
    end

    always_comb begin
        res_next    = {a_sign, rounded[DST_EXP_BITS+DST_MAN_BITS-1:0]};
        status_next = {2'b00, 1'b0, 1'b0, inexact};
        if (a_zero) begin
            res_next    = '0;
            status_next = '0;
        end else if (overflow) begin
            status_next = {2'b00, 1'b1, 1'b0, 1'b1};
            if (use_inf) begin
                res_next = {a_sign, {DST_EXP_BITS{1'b1}}, {DST_MAN_BITS{1'b0}}};
            end else begin
                res_next = {a_sign, {(DST_EXP_BITS-1){1'b1}}, 1'b0,
                            {DST_MAN_BITS{1'b1}}};
            end
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_valid  <= 1'b0;
            a_sign   <= 1'b0;
            a_mag    <= '0;
            a_zero   <= 1'b0;
            a_rnd    <= '0;
            a_tag    <= '0;
            b_valid  <= 1'b0;
            b_result <= '0;
            b_status <= '0;
            b_tag    <= '0;
        end else if (flush_i) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (a_adv) begin
                a_valid <= in_valid_i;
                if (in_valid_i) begin
                    a_sign <= in_sign;
                    a_mag  <= in_mag;
                    a_zero <= (in_mag == '0);
                    a_rnd  <= rnd_mode_i;
                    a_tag  <= tag_i;
                end
            end
            if (b_adv) begin
                b_valid <= a_valid;
                // Data is loaded only when a new operation arrives, so a
                // stalled output holds its values.
                if (a_valid) begin
                    b_result <= res_next;
                    b_status <= status_next;
                    b_tag    <= a_tag;
                end
            end
        end
    end

    assign result_o        = b_result;
    assign status_o        = b_status;
    assign tag_o           = b_tag;
    assign out_valid_o     = b_valid;
    assign busy_o          = a_valid | b_valid;
    assign extension_bit_o = 1'b1;

endmodule

// File: tb/tb_fpnew_i2fcast_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for fpnew_i2fcast_pipe.
// Two instances are used: FP32 and FP16 destinations, both with 32-bit
// integers and 8-bit tags. The stimulus is directed vectors with
// hand-computed results.
// ---------------------------------------------------------------------------
module tb_fpnew_i2fcast_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] operand;
    logic        is_signed;
    logic [2:0]  rnd_mode;
    logic [7:0]  tag_in;
    logic        flush;
    logic        out_ready;

    logic        in_valid32, in_ready32, out_valid32, busy32, ext32;
    logic [31:0] res32;
    logic [4:0]  st32;
    logic [7:0]  tag32;

    logic        in_valid16, in_ready16, out_valid16, busy16, ext16;
    logic [15:0] res16;
    logic [4:0]  st16;
    logic [7:0]  tag16;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fpnew_i2fcast_pipe #(.IntWidth(32), .DstFpFormat(0), .TagType(logic [7:0])) u_fp32 (
        .clk_i(clk), .rst_i(rst), .operand_i(operand), .is_signed_i(is_signed),
        .rnd_mode_i(rnd_mode), .tag_i(tag_in), .in_valid_i(in_valid32),
        .in_ready_o(in_ready32), .flush_i(flush), .result_o(res32),
        .status_o(st32), .extension_bit_o(ext32), .tag_o(tag32),
        .out_valid_o(out_valid32), .out_ready_i(out_ready), .busy_o(busy32)
    );

    fpnew_i2fcast_pipe #(.IntWidth(32), .DstFpFormat(2), .TagType(logic [7:0])) u_fp16 (
        .clk_i(clk), .rst_i(rst), .operand_i(operand), .is_signed_i(is_signed),
        .rnd_mode_i(rnd_mode), .tag_i(tag_in), .in_valid_i(in_valid16),
        .in_ready_o(in_ready16), .flush_i(flush), .result_o(res16),
        .status_o(st16), .extension_bit_o(ext16), .tag_o(tag16),
        .out_valid_o(out_valid16), .out_ready_i(out_ready), .busy_o(busy16)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one operation into the selected instance with out_ready held
    // high. The operation is taken at the first edge. The result must not
    // be visible after that edge, and must be visible after the next one.
    task automatic run_op(input string name, input bit use16, input logic [31:0] op,
                          input bit sgn, input logic [2:0] rm, input logic [7:0] tg,
                          input logic [31:0] exp_res, input logic [4:0] exp_st);
        operand   = op;
        is_signed = sgn;
        rnd_mode  = rm;
        tag_in    = tg;
        out_ready = 1'b1;
        if (use16) in_valid16 = 1'b1; else in_valid32 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        in_valid32 = 1'b0;
        check_eq({name, "_early"}, use16 ? out_valid16 : out_valid32, 0);
        tick();
        check_eq({name, "_valid"}, use16 ? out_valid16 : out_valid32, 1);
        check_eq({name, "_res"}, use16 ? {16'h0, res16} : res32, exp_res);
        check_eq({name, "_st"}, use16 ? st16 : st32, exp_st);
        check_eq({name, "_tag"}, use16 ? tag16 : tag32, tg);
        $display("[TB] op %s operand=0x%08h res=0x%08h status=0x%02h", name, op,
                 use16 ? {16'h0, res16} : res32, use16 ? st16 : st32);
        tick();
    endtask

    logic [31:0] bp_ops [4] = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] bp_exp [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'hBF80_0000};

    initial begin
        int sent, recv;
        logic [31:0] held;
        bit have_held;
        bit seen;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        operand = '0; is_signed = 1'b0; rnd_mode = 3'd0; tag_in = '0;
        in_valid32 = 1'b0; in_valid16 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_valid", out_valid32, 0);
        check_eq("rst_busy", busy32, 0);
        check_eq("rst_res", res32, 0);
        check_eq("rst_st", st32, 0);
        check_eq("rst_tag", tag32, 0);
        check_eq("ext_bit32", ext32, 1);
        check_eq("ext_bit16", ext16, 1);

        // FP32 directed vectors
        run_op("s_one_rne",   0, 32'd1,          1, 3'd0, 8'h11, 32'h3F80_0000, 5'h00);
        run_op("s_mone_rne",  0, 32'hFFFF_FFFF,  1, 3'd0, 8'h12, 32'hBF80_0000, 5'h00);
        run_op("s_zero_rne",  0, 32'd0,          1, 3'd0, 8'h13, 32'h0000_0000, 5'h00);
        run_op("s_zero_rdn",  0, 32'd0,          1, 3'd2, 8'h14, 32'h0000_0000, 5'h00);
        run_op("s_2p24p1_rne",0, 32'h0100_0001,  1, 3'd0, 8'h15, 32'h4B80_0000, 5'h01);
        run_op("s_2p24p1_rup",0, 32'h0100_0001,  1, 3'd3, 8'h16, 32'h4B80_0001, 5'h01);
        run_op("s_2p24p1_rtz",0, 32'h0100_0001,  1, 3'd1, 8'h17, 32'h4B80_0000, 5'h01);
        run_op("s_min_rne",   0, 32'h8000_0000,  1, 3'd0, 8'h18, 32'hCF00_0000, 5'h00);
        run_op("u_max_rne",   0, 32'hFFFF_FFFF,  0, 3'd0, 8'h19, 32'h4F80_0000, 5'h01);
        run_op("u_max_rtz",   0, 32'hFFFF_FFFF,  0, 3'd1, 8'h1A, 32'h4F7F_FFFF, 5'h01);
        run_op("u_five_rmm",  0, 32'd5,          0, 3'd4, 8'h1B, 32'h40A0_0000, 5'h00);

        // FP16 overflow behaviour
        run_op("h_70000_rne", 1, 32'd70000,      1, 3'd0, 8'h21, 32'h0000_7C00, 5'h05);
        run_op("h_70000_rtz", 1, 32'd70000,      1, 3'd1, 8'h22, 32'h0000_7BFF, 5'h05);
        run_op("h_m70000_rdn",1, 32'hFFFE_EE90,  1, 3'd2, 8'h23, 32'h0000_FC00, 5'h05);
        run_op("h_m70000_rup",1, 32'hFFFE_EE90,  1, 3'd3, 8'h24, 32'h0000_FBFF, 5'h05);
        run_op("h_one_rne",   1, 32'd1,          1, 3'd0, 8'h25, 32'h0000_3C00, 5'h00);

        // Backpressure: out_ready stays low for cycles 0..6.
        // The output is stalled on cycles 2..6.
        sent = 0; recv = 0; have_held = 0; held = '0;
        is_signed = 1'b1; rnd_mode = 3'd0;
        for (int c = 0; c < 40 && recv < 4; c++) begin
            in_valid32 = (sent < 4);
            operand    = (sent < 4) ? bp_ops[sent] : 32'd0;
            tag_in     = 8'hA0 + 8'(sent);
            out_ready  = (c >= 7);
            #1;
            if (c == 5) begin
                check_eq("bp_in_ready_low", in_ready32, 0);
                check_eq("bp_accepted", sent, 2);
            end
            if (out_valid32 && !out_ready) begin
                if (have_held) check_eq("bp_hold", res32, held);
                held = res32;
                have_held = 1;
            end
            if (out_valid32 && out_ready) begin
                check_eq("bp_res", res32, bp_exp[recv]);
                check_eq("bp_tag", tag32, 8'hA0 + 8'(recv));
                $display("[TB] bp out #%0d res=0x%08h tag=0x%02h", recv, res32, tag32);
                recv++;
            end
            if (in_valid32 && in_ready32) sent++;
            tick();
        end
        in_valid32 = 1'b0;
        check_eq("bp_all_out", recv, 4);
        tick();

        // Flush with two operations in flight
        out_ready = 1'b0; operand = 32'd7; tag_in = 8'h55; in_valid32 = 1'b1;
        tick(); tick();
        check_eq("fl_busy_before", busy32, 1);
        flush = 1'b1;
        #1;
        check_eq("fl_in_ready", in_ready32, 0);
        tick();
        flush = 1'b0; in_valid32 = 1'b0; out_ready = 1'b1;
        check_eq("fl_valid", out_valid32, 0);
        check_eq("fl_busy", busy32, 0);
        seen = 0;
        repeat (4) begin tick(); if (out_valid32) seen = 1; end
        check_eq("fl_no_stale", seen, 0);
        $display("[TB] flush done");

        // Reset with two operations in flight
        out_ready = 1'b0; operand = 32'd9; tag_in = 8'h66; in_valid32 = 1'b1;
        tick(); tick();
        check_eq("rs_busy_before", busy32, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid32 = 1'b0; out_ready = 1'b1;
        check_eq("rs_valid", out_valid32, 0);
        check_eq("rs_busy", busy32, 0);
        check_eq("rs_res", res32, 0);
        check_eq("rs_st", st32, 0);
        check_eq("rs_tag", tag32, 0);
        seen = 0;
        repeat (4) begin tick(); if (out_valid32) seen = 1; end
        check_eq("rs_no_stale", seen, 0);
        $display("[TB] reset done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
